// File: rtl/instr_feeder_pkg.sv
// Shared types and constants for the instruction feeder: FSM states, opcode
// encodings and default geometry.
package instr_feeder_pkg;

   localparam int DEF_ADDR_W  = 5;
   localparam int DEF_TIMEOUT = 8;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ISSUE  = 3'd1,
      S_IMM    = 3'd2,
      S_WAIT   = 3'd3,
      S_FINISH = 3'd4,
      S_FAULT  = 3'd5
   } state_t;

   localparam logic [2:0] OP_MV  = 3'b000;
   localparam logic [2:0] OP_MVI = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;

endpackage

// File: rtl/instr_feeder_if.sv
// Host/processor-facing bundle of the instruction feeder. Run is a one-cycle
// launch pulse; Done is a level sampled each cycle, only meaningful after Run.
interface instr_feeder_if
   import instr_feeder_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
);
   logic              LoadEn;
   logic [ADDR_W-1:0] LoadAddr;
   logic [15:0]       LoadData;
   logic [ADDR_W:0]   Length;
   logic              Start;
   logic              Done;
   logic [15:0]       DIN;
   logic              Run;
   logic              Busy;
   logic              Finished;
   logic              Error;
   logic [ADDR_W:0]   PC;
   state_t            state_dbg;

   modport master (
      output LoadEn, LoadAddr, LoadData, Length, Start, Done,
      input  DIN, Run, Busy, Finished, Error, PC, state_dbg
   );

   modport slave (
      input  LoadEn, LoadAddr, LoadData, Length, Start, Done,
      output DIN, Run, Busy, Finished, Error, PC, state_dbg
   );
endinterface

// File: rtl/instr_feeder_prog_mem.sv
// Program store: 2^ADDR_W x 16, synchronous write, combinational read.
module prog_mem #(
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [15:0]       wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [15:0]       rdata
);
   logic [15:0] mem [2**ADDR_W];

   // No reset: the program survives a Reset of the sequencer.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/instr_feeder.sv
// Instruction feeder: steps through a loaded program, launching each word to a
// processor with Run and waiting for Done, with mvi immediates and a timeout.
module instr_feeder
   import instr_feeder_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic           Clock,
   input  logic           Reset,
   instr_feeder_if.slave  bus
);
   localparam int TMO_W = $clog2(TIMEOUT + 1);

   state_t            state_q, state_d;
   logic [ADDR_W:0]   pc_q, pc_d, len_q, len_d, pc_inc;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic              fin_q, fin_d, err_q, err_d;
   logic [15:0]       rd_data, din, last_q;
   logic [2:0]        opcode;
   logic              tmo_last, mem_we;

   assign mem_we = bus.LoadEn && (state_q == S_IDLE);

   prog_mem #(.ADDR_W(ADDR_W)) u_mem (
      .clk   (Clock),
      .we    (mem_we),
      .waddr (bus.LoadAddr),
      .wdata (bus.LoadData),
      .raddr (pc_q[ADDR_W-1:0]),
      .rdata (rd_data)
   );

   assign pc_inc = pc_q + 1'b1;
   assign opcode = rd_data[8:6];
   // Window counts the Run cycle itself, so the last WAIT/IMM cycle is TIMEOUT-1 after Run.
   assign tmo_last = (32'(tmo_q) + 32'd2) >= 32'(TIMEOUT);
   assign din = (state_q == S_ISSUE || state_q == S_IMM) ? rd_data : last_q;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         len_q   <= '0;
         tmo_q   <= '0;
         fin_q   <= 1'b0;
         err_q   <= 1'b0;
         last_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         len_q   <= len_d;
         tmo_q   <= tmo_d;
         fin_q   <= fin_d;
         err_q   <= err_d;
         last_q  <= din;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      len_d   = len_q;
      tmo_d   = tmo_q;
      fin_d   = fin_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (bus.Start) begin
               len_d = bus.Length;
               pc_d  = '0;
               err_d = 1'b0;
               fin_d = (bus.Length == '0);
               state_d = (bus.Length == '0) ? S_FINISH : S_ISSUE;
            end
         end
         S_ISSUE: begin
            tmo_d = '0;
            if (opcode == OP_MVI) begin
               // An mvi with no room left for its immediate is a malformed program.
               if (pc_inc == len_q) begin
                  err_d   = 1'b1;
                  state_d = S_FAULT;
               end else begin
                  pc_d    = pc_inc;
                  state_d = S_IMM;
               end
            end else begin
               state_d = S_WAIT;
            end
         end
         S_IMM, S_WAIT: begin
            if (bus.Done) begin
               pc_d = pc_inc;
               if (pc_inc == len_q) begin
                  fin_d   = 1'b1;
                  state_d = S_FINISH;
               end else begin
                  state_d = S_ISSUE;
               end
            end else if (tmo_last) begin
               err_d   = 1'b1;
               state_d = S_FAULT;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         S_FINISH, S_FAULT: state_d = S_IDLE;
         default:           state_d = S_IDLE;
      endcase
   end

   assign bus.DIN       = din;
   assign bus.Run       = (state_q == S_ISSUE);
   assign bus.Busy      = (state_q == S_ISSUE) || (state_q == S_IMM) || (state_q == S_WAIT);
   assign bus.Finished  = fin_q;
   assign bus.Error     = err_q;
   assign bus.PC        = pc_q;
   assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_instr_feeder.sv
// Directed bench for instr_feeder: table of whole-program runs with a Done
// responder, plus hand sequences for reset behaviour.
module tb_instr_feeder;
   import instr_feeder_pkg::*;

   localparam int AW = 5;
   localparam int TO = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   instr_feeder_if #(.ADDR_W(AW)) bus ();

   instr_feeder #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
      .Clock (clk),
      .Reset (rst),
      .bus   (bus.slave)
   );

   typedef struct {
      logic [63:0] name;
      logic [15:0] prog [3];
      logic [AW:0] len;
      int          dly [3];   // Done this many cycles after the n-th Run; 0 = never
      bit          keep;      // reuse memory as left by the previous run
      bit          poke;      // pulse LoadEn/Start during the first Run cycle
      int          exp_runs;
      bit          exp_fin;
      bit          exp_err;
      logic [AW:0] exp_pc;
      int          exp_total; // cycles from Start to Finished/Error
      logic [15:0] exp_din0;
      logic [15:0] exp_after0;
   } rec_t;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic rec_t mk(input logic [63:0] name,
                               input logic [15:0] p0, input logic [15:0] p1, input logic [15:0] p2,
                               input int len, input int d0, input int d1, input int d2,
                               input bit keep, input bit poke, input int runs,
                               input bit fin, input bit err, input int pc, input int total,
                               input logic [15:0] din0, input logic [15:0] after0);
      rec_t r;
      r.name = name;
      r.prog[0] = p0; r.prog[1] = p1; r.prog[2] = p2;
      r.len = (AW+1)'(len);
      r.dly[0] = d0; r.dly[1] = d1; r.dly[2] = d2;
      r.keep = keep; r.poke = poke;
      r.exp_runs = runs; r.exp_fin = fin; r.exp_err = err;
      r.exp_pc = (AW+1)'(pc); r.exp_total = total;
      r.exp_din0 = din0; r.exp_after0 = after0;
      return r;
   endfunction

   task automatic load(input int addr, input logic [15:0] data);
      bus.LoadEn   = 1'b1;
      bus.LoadAddr = AW'(addr);
      bus.LoadData = data;
      tick();
      bus.LoadEn   = 1'b0;
   endtask

   task automatic run_rec(input rec_t r);
      int cyc = 0;
      int runs = 0;
      int cnt = 0;
      int end_cyc = -1;
      bit prev_run = 1'b0;
      logic [15:0] din0 = '0;
      logic [15:0] after0 = '0;
      string nm;
      nm = $sformatf("%0s", r.name);
      if (!r.keep)
         for (int i = 0; i < int'(r.len) && i < 3; i++) load(i, r.prog[i]);
      bus.Length = r.len;
      bus.Start  = 1'b1;
      tick();
      bus.Start  = 1'b0;
      cyc = 1;
      while (cyc < 100 && end_cyc < 0) begin
         bus.LoadEn = 1'b0;
         bus.Start  = 1'b0;
         if (prev_run && runs == 1) after0 = bus.DIN;
         if (bus.Run) begin
            runs++;
            if (runs == 1) din0 = bus.DIN;
            cnt = (runs <= 3) ? r.dly[runs-1] : 0;
            bus.Done = 1'b0;
            if (r.poke && runs == 1) begin
               bus.LoadEn   = 1'b1;
               bus.LoadAddr = '0;
               bus.LoadData = 16'hBEEF;
               bus.Start    = 1'b1;
               bus.Length   = '0;
            end
         end else if (cnt > 0) begin
            cnt--;
            bus.Done = (cnt == 0);
         end else begin
            bus.Done = 1'b0;
         end
         prev_run = bus.Run;
         if (bus.Finished || bus.Error) begin
            end_cyc  = cyc;
            bus.Done = 1'b0;
         end else begin
            tick();
            cyc++;
         end
      end
      bus.Done = 1'b0;
      chk({nm, "_ended"}, (end_cyc >= 0), 1);
      chk({nm, "_runs"}, runs, r.exp_runs);
      chk({nm, "_finished"}, bus.Finished, r.exp_fin);
      chk({nm, "_error"}, bus.Error, r.exp_err);
      chk({nm, "_pc"}, bus.PC, r.exp_pc);
      chk({nm, "_cycles"}, end_cyc, r.exp_total);
      chk({nm, "_busy_end"}, bus.Busy, 0);
      if (r.exp_runs > 0) begin
         chk({nm, "_din_run"}, din0, r.exp_din0);
         chk({nm, "_din_next"}, after0, r.exp_after0);
      end
      tick();
      chk({nm, "_flags_held"}, {bus.Finished, bus.Error, bus.Run, bus.Busy},
          {r.exp_fin, r.exp_err, 1'b0, 1'b0});
   endtask

   rec_t tbl [9];

   initial begin
      int runs_after_reset;
      rec_t tail_rerun, tail_len0;

      bus.LoadEn = 1'b0; bus.LoadAddr = '0; bus.LoadData = '0;
      bus.Length = '0;   bus.Start = 1'b0;  bus.Done = 1'b0;

      //          name        p0        p1        p2    len d0 d1 d2 keep poke runs fin err pc tot din0      after0
      tbl[0] = mk("mv1",     16'h0008, 16'h0000, 16'h0000, 1, 2, 0, 0, 0, 0, 1, 1, 0, 1,  4, 16'h0008, 16'h0008);
      tbl[1] = mk("mvi",     16'h0040, 16'h1234, 16'h0000, 2, 1, 0, 0, 0, 0, 1, 1, 0, 2,  3, 16'h0040, 16'h1234);
      tbl[2] = mk("three",   16'h0008, 16'h0091, 16'h00D2, 3, 2, 1, 3, 0, 0, 3, 1, 0, 3, 10, 16'h0008, 16'h0008);
      tbl[3] = mk("timeout", 16'h0008, 16'h0091, 16'h00D2, 3, 1, 0, 0, 0, 0, 2, 0, 1, 1, 11, 16'h0008, 16'h0008);
      // The second word here is an instruction, so a trailing mvi has no immediate.
      tbl[4] = mk("mvi_end", 16'h0008, 16'h0040, 16'h0000, 2, 1, 0, 0, 0, 0, 2, 0, 1, 1,  4, 16'h0008, 16'h0008);
      tbl[5] = mk("mvi_one", 16'h0040, 16'h0000, 16'h0000, 1, 1, 0, 0, 0, 0, 1, 0, 1, 0,  2, 16'h0040, 16'h0040);
      tbl[6] = mk("len0",    16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0,  1, 16'h0000, 16'h0000);
      tbl[7] = mk("poke",    16'h0008, 16'h0000, 16'h0000, 1, 3, 0, 0, 0, 1, 1, 1, 0, 1,  5, 16'h0008, 16'h0008);
      tbl[8] = mk("rerun",   16'h0000, 16'h0000, 16'h0000, 1, 1, 0, 0, 1, 0, 1, 1, 0, 1,  3, 16'h0008, 16'h0008);
      tail_rerun = mk("rst_mem", 16'h0000, 16'h0000, 16'h0000, 1, 2, 0, 0, 1, 0, 1, 1, 0, 1, 4, 16'h0008, 16'h0008);
      tail_len0  = mk("rst_len0", 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 16'h0000, 16'h0000);

      tick();
      tick();
      chk("reset_outputs", {bus.DIN, bus.Run, bus.Busy, bus.Finished, bus.Error, bus.PC},
          {16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0});
      rst = 1'b0;
      tick();

      for (int i = 0; i < 9; i++) run_rec(tbl[i]);

      // Abort from WAIT: memory still holds 0x0008 at address 0.
      bus.Length = 6'd1;
      bus.Start  = 1'b1;
      tick();
      bus.Start  = 1'b0;
      chk("abort_run", bus.Run, 1);
      tick();
      chk("abort_in_wait", {bus.Busy, bus.DIN}, {1'b1, 16'h0008});
      rst = 1'b1;
      tick();
      chk("abort_reset_outputs", {bus.DIN, bus.Run, bus.Busy, bus.Finished, bus.Error, bus.PC},
          {16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0});
      rst = 1'b0;
      runs_after_reset = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (bus.Run) runs_after_reset++;
      end
      chk("abort_no_run", runs_after_reset, 0);
      run_rec(tail_len0);
      run_rec(tail_rerun);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
